// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the instruction register / datapath and the multi-cycle sequencer.
// master = sequencer side (drives enables), slave = datapath side.
interface multicycle_control_fsm_if;
  logic [3:0] opcode;
  logic [3:0] funct;
  logic       zero;
  logic       memReady;
  logic       irWrite;
  logic       pcWrite;
  logic       pcSrc;
  logic       regDest;
  logic       aluSrc;
  logic       extOp;
  logic [2:0] aluCtr;
  logic       memRead;
  logic       memWrite;
  logic       memToReg;
  logic       regWrite;
  logic       instrDone;
  logic       busError;
  logic       illegalInstr;

  modport master (
    input  opcode, funct, zero, memReady,
    output irWrite, pcWrite, pcSrc, regDest, aluSrc, extOp, aluCtr,
           memRead, memWrite, memToReg, regWrite, instrDone, busError, illegalInstr
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  irWrite, pcWrite, pcSrc, regDest, aluSrc, extOp, aluCtr,
           memRead, memWrite, memToReg, regWrite, instrDone, busError, illegalInstr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout.
// Define ILLEGAL_TRAP_EN to halt on undefined opcode/funct; otherwise they retire as NOPs.
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_fsm_if.master   bus
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ORI  = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_SW   = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic       bus_error_reg;
  logic       legal;
  logic       timeout;
  logic [2:0] alu_op;

  always_comb begin
    legal   = (bus.opcode <= OP_BEQ) && ((bus.opcode != OP_R) || (bus.funct <= 4'b0101));
    timeout = (state_reg == S_FETCH || state_reg == S_MEM) && !bus.memReady
              && (wait_cnt_reg == WAIT_LAST);
  end

  always_comb begin
    alu_op = 3'b010;
    unique case (bus.opcode)
      OP_R: begin
        unique case (bus.funct)
          4'b0001: alu_op = 3'b110;
          4'b0010: alu_op = 3'b000;
          4'b0011: alu_op = 3'b001;
          4'b0100: alu_op = 3'b111;
          4'b0101: alu_op = 3'b011;
          default: alu_op = 3'b010;
        endcase
      end
      OP_ORI:  alu_op = 3'b001;
      OP_BEQ:  alu_op = 3'b110;
      default: alu_op = 3'b010;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_FETCH;
      wait_cnt_reg  <= 8'd0;
      bus_error_reg <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_reg   <= 1'b0;
`endif
    end else begin
      wait_cnt_reg <= 8'd0;
      unique case (state_reg)
        S_FETCH: begin
          if (bus.memReady) begin
            state_reg <= S_DECODE;
          end else if (timeout) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        S_DECODE: begin
          if (legal) begin
            state_reg <= S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_reg   <= S_HALT;
            illegal_reg <= 1'b1;
`else
            state_reg <= S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          unique case (bus.opcode)
            OP_R, OP_ADDI, OP_ORI: state_reg <= S_WB;
            OP_LW, OP_SW:          state_reg <= S_MEM;
            default:               state_reg <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (bus.memReady) begin
            state_reg <= (bus.opcode == OP_LW) ? S_WB : S_FETCH;
          end else if (timeout) begin
            state_reg     <= S_HALT;
            bus_error_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        S_WB:    state_reg <= S_FETCH;
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // Enables are decoded from the current step and forced low while reset is held,
  // so a write in flight during reset never reaches the datapath.
  always_comb begin
    bus.irWrite   = 1'b0;
    bus.pcWrite   = 1'b0;
    bus.pcSrc     = 1'b0;
    bus.regDest   = 1'b0;
    bus.aluSrc    = 1'b0;
    bus.extOp     = 1'b0;
    bus.aluCtr    = 3'b000;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.memToReg  = 1'b0;
    bus.regWrite  = 1'b0;
    bus.instrDone = 1'b0;
    if (!reset) begin
      unique case (state_reg)
        S_FETCH: begin
          bus.memRead = 1'b1;
          bus.irWrite = bus.memReady;
          bus.pcWrite = bus.memReady;
        end
        S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
          bus.instrDone = !legal;
`endif
        end
        S_EXEC: begin
          bus.aluSrc  = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ORI) ||
                        (bus.opcode == OP_LW)   || (bus.opcode == OP_SW);
          bus.extOp   = (bus.opcode != OP_R) && (bus.opcode != OP_ORI);
          bus.aluCtr  = alu_op;
          bus.regDest = (bus.opcode == OP_R);
          if (bus.opcode == OP_BEQ) begin
            bus.pcWrite   = bus.zero;
            bus.pcSrc     = 1'b1;
            bus.instrDone = 1'b1;
          end
        end
        S_MEM: begin
          bus.memRead   = (bus.opcode == OP_LW);
          bus.memWrite  = (bus.opcode == OP_SW);
          bus.instrDone = (bus.opcode == OP_SW) && bus.memReady;
        end
        S_WB: begin
          bus.regWrite  = 1'b1;
          bus.memToReg  = (bus.opcode == OP_LW);
          bus.regDest   = (bus.opcode == OP_R);
          bus.instrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busError = bus_error_reg & ~reset;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegalInstr = illegal_reg & ~reset;
`else
  assign bus.illegalInstr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed per-cycle vectors for the multi-cycle sequencer; stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm #(.MEM_WAIT_MAX(15)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  // Output vector bit positions
  localparam logic [15:0] IR   = 16'h8000;
  localparam logic [15:0] PCW  = 16'h4000;
  localparam logic [15:0] PCS  = 16'h2000;
  localparam logic [15:0] RD   = 16'h1000;
  localparam logic [15:0] ASRC = 16'h0800;
  localparam logic [15:0] EXT  = 16'h0400;
  localparam logic [15:0] MR   = 16'h0040;
  localparam logic [15:0] MW   = 16'h0020;
  localparam logic [15:0] M2R  = 16'h0010;
  localparam logic [15:0] RW   = 16'h0008;
  localparam logic [15:0] DONE = 16'h0004;
  localparam logic [15:0] BERR = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;
  localparam logic [15:0] FOK  = IR | PCW | MR;

  function automatic logic [15:0] alu(input logic [2:0] a);
    return {6'b0, a, 7'b0};
  endfunction

  typedef struct {
    logic [15:0] exp;
    string       name;
  } item_t;
  item_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] obs;
  assign obs = {bus.irWrite, bus.pcWrite, bus.pcSrc, bus.regDest, bus.aluSrc, bus.extOp,
                bus.aluCtr, bus.memRead, bus.memWrite, bus.memToReg, bus.regWrite,
                bus.instrDone, bus.busError, bus.illegalInstr};

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      it = sb_q.pop_front();
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.name, obs, it.exp);
      end else begin
        $display("ok   %s: %h", it.name, obs);
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input logic z,
                      input logic [3:0] op, input logic [3:0] fn,
                      input logic [15:0] exp, input string name);
    item_t it;
    reset        = r;
    bus.memReady = rdy;
    bus.zero     = z;
    bus.opcode   = op;
    bus.funct    = fn;
    it.exp  = exp;
    it.name = name;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Four-cycle instruction (R/ADDI/ORI) with memReady tied high
  task automatic run4(input logic [3:0] op, input logic [3:0] fn,
                      input logic [15:0] exec_exp, input logic [15:0] wb_exp, input string tag);
    step(0, 1, 0, op, fn, FOK,      {tag, "_fetch"});
    step(0, 1, 0, op, fn, 16'h0,    {tag, "_decode"});
    step(0, 1, 0, op, fn, exec_exp, {tag, "_exec"});
    step(0, 1, 0, op, fn, wb_exp,   {tag, "_wb"});
  endtask

  initial begin
    reset = 1'b1;
    bus.memReady = 1'b1;
    bus.zero = 1'b0;
    bus.opcode = 4'h0;
    bus.funct = 4'h0;
    @(posedge clk);
    #1;
    step(1, 1, 0, 4'h0, 4'h0, 16'h0, "reset_a");
    step(1, 1, 0, 4'h0, 4'h0, 16'h0, "reset_b");
    step(0, 0, 0, 4'h0, 4'h0, MR,    "fetch_first");

    run4(4'h0, 4'h1, RD | alu(3'b110),         RW | DONE | RD, "r_sub");
    run4(4'h0, 4'h4, RD | alu(3'b111),         RW | DONE | RD, "r_slt");
    run4(4'h0, 4'h5, RD | alu(3'b011),         RW | DONE | RD, "r_xor");
    run4(4'h1, 4'h0, ASRC | EXT | alu(3'b010), RW | DONE,      "addi");
    run4(4'h2, 4'h0, ASRC | alu(3'b001),       RW | DONE,      "ori");

    // LW with three wait cycles in MEM: eight cycles total
    step(0, 1, 0, 4'h3, 4'h0, FOK,                      "lw_fetch");
    step(0, 1, 0, 4'h3, 4'h0, 16'h0,                    "lw_decode");
    step(0, 1, 0, 4'h3, 4'h0, ASRC | EXT | alu(3'b010), "lw_exec");
    step(0, 0, 0, 4'h3, 4'h0, MR,                       "lw_mem_w1");
    step(0, 0, 0, 4'h3, 4'h0, MR,                       "lw_mem_w2");
    step(0, 0, 0, 4'h3, 4'h0, MR,                       "lw_mem_w3");
    step(0, 1, 0, 4'h3, 4'h0, MR,                       "lw_mem_rdy");
    step(0, 1, 0, 4'h3, 4'h0, RW | DONE | M2R,          "lw_wb");

    step(0, 1, 0, 4'h4, 4'h0, FOK,                      "sw_fetch");
    step(0, 1, 0, 4'h4, 4'h0, 16'h0,                    "sw_decode");
    step(0, 1, 0, 4'h4, 4'h0, ASRC | EXT | alu(3'b010), "sw_exec");
    step(0, 1, 0, 4'h4, 4'h0, MW | DONE,                "sw_mem");

    step(0, 1, 1, 4'h5, 4'h0, FOK,                                "beq_t_fetch");
    step(0, 1, 1, 4'h5, 4'h0, 16'h0,                              "beq_t_decode");
    step(0, 1, 1, 4'h5, 4'h0, EXT | alu(3'b110) | PCW | PCS | DONE, "beq_t_exec");
    step(0, 1, 0, 4'h5, 4'h0, FOK,                                "beq_nt_fetch");
    step(0, 1, 0, 4'h5, 4'h0, 16'h0,                              "beq_nt_decode");
    step(0, 1, 0, 4'h5, 4'h0, EXT | alu(3'b110) | PCS | DONE,     "beq_nt_exec");

    // Undefined opcode 1001
    step(0, 1, 0, 4'h9, 4'h0, FOK, "ill_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(0, 1, 0, 4'h9, 4'h0, 16'h0, "ill_decode");
    step(0, 0, 0, 4'h9, 4'h0, ILL,   "ill_halt_a");
    step(0, 1, 0, 4'h9, 4'h0, ILL,   "ill_halt_b");
`else
    step(0, 1, 0, 4'h9, 4'h0, DONE,  "ill_decode");
    step(0, 0, 0, 4'h9, 4'h0, MR,    "ill_refetch");
    step(0, 0, 0, 4'h9, 4'h0, MR,    "ill_refetch_b");
`endif
    step(1, 1, 0, 4'h0, 4'h0, 16'h0, "ill_reset");

    // Undefined R-type funct 0111
    step(0, 1, 0, 4'h0, 4'h7, FOK, "illf_fetch");
`ifdef ILLEGAL_TRAP_EN
    step(0, 1, 0, 4'h0, 4'h7, 16'h0, "illf_decode");
    step(0, 1, 0, 4'h0, 4'h7, ILL,   "illf_halt");
`else
    step(0, 1, 0, 4'h0, 4'h7, DONE,  "illf_decode");
    step(0, 0, 0, 4'h0, 4'h7, MR,    "illf_refetch");
`endif
    step(1, 1, 0, 4'h0, 4'h0, 16'h0, "illf_reset");

    // Reset during SW's MEM step drops the write
    step(0, 1, 0, 4'h4, 4'h0, FOK,                      "swr_fetch");
    step(0, 1, 0, 4'h4, 4'h0, 16'h0,                    "swr_decode");
    step(0, 1, 0, 4'h4, 4'h0, ASRC | EXT | alu(3'b010), "swr_exec");
    step(1, 1, 0, 4'h4, 4'h0, 16'h0,                    "swr_reset");
    step(0, 1, 0, 4'h4, 4'h0, FOK,                      "swr_refetch");
    step(1, 1, 0, 4'h0, 4'h0, 16'h0,                    "swr_reset_b");

    // memReady stuck low in FETCH: 15 waiting cycles, then HALT with busError
    for (int i = 0; i < 15; i++) step(0, 0, 0, 4'h0, 4'h0, MR, $sformatf("berr_wait%0d", i));
    step(0, 0, 0, 4'h0, 4'h0, BERR, "berr_halt_a");
    step(0, 1, 0, 4'h3, 4'h0, BERR, "berr_halt_b");
    step(0, 1, 0, 4'h4, 4'h0, BERR, "berr_halt_c");
    step(1, 1, 0, 4'h0, 4'h0, 16'h0, "berr_reset");
    step(0, 1, 0, 4'h0, 4'h0, FOK,   "berr_after");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
